// File: rtl/divider_16.sv
// rtl/divider_16.sv - multi-cycle unsigned restoring divider with start/done handshake
module divider_16 #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] shf_q, shf_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Partial remainder stays below the divisor, so WIDTH bits hold it between steps;
  // the shifted value and trial difference need the extra bit.
  assign shifted = {rem_q, shf_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    shf_d   = shf_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d = S_DONE;
            quo_d   = '1;
            rmd_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
            shf_d   = dividend;
            dvs_d   = divisor;
            rem_d   = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          shf_d = {shf_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          shf_d = {shf_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          quo_d   = shf_d;
          rmd_d   = rem_d;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status flags are registered from the next state so they line up with it.
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      shf_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      shf_q   <= shf_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_16.sv
// tb/tb_divider_16.sv - scoreboard bench for divider_16
module tb_divider_16;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient, remainder;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  logic prev_done = 1'b0;

  divider_16 #(.WIDTH(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(negedge Clk);
    total++;
    if (busy && done) begin
      bad++;
      $display("FAIL busy_done_excl: busy=%b done=%b required not both high", busy, done);
    end
    total++;
    if (done && prev_done) begin
      bad++;
      $display("FAIL done_width: done high two cycles in a row, required one");
    end
    prev_done = done;
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = 16'hFFFF; e.r = a; e.z = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 1'b0;
    end
    return e;
  endfunction

  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sbq.push_back(model(a, b));
    tick();
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_done(input string name, output int cyc, output int busyc);
    exp_t e;
    cyc = 0;
    busyc = 0;
    while (!done && cyc < 40) begin
      if (busy) busyc++;
      tick();
      cyc++;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, cyc);
    end else if (sbq.size() == 0) begin
      bad++;
      $display("FAIL %s_sb_empty: done with no expected result queued", name);
    end else begin
      e = sbq.pop_front();
      total++;
      if (quotient !== e.q) begin
        bad++;
        $display("FAIL %s_quotient: got %0d expected %0d", name, quotient, e.q);
      end
      total++;
      if (remainder !== e.r) begin
        bad++;
        $display("FAIL %s_remainder: got %0d expected %0d", name, remainder, e.r);
      end
      total++;
      if (div_by_zero !== e.z) begin
        bad++;
        $display("FAIL %s_dbz: got %b expected %b", name, div_by_zero, e.z);
      end
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) tick();
    total++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 35'd0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b dbz=%b q=%0d r=%0d required all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int cyc, busyc;
    start_op(16'd100, 16'd7);
    wait_done("basic", cyc, busyc);
    total++;
    if (cyc != 16) begin
      bad++;
      $display("FAIL basic_latency: done after %0d cycles, required 16", cyc);
    end
    total++;
    if (busyc != 16) begin
      bad++;
      $display("FAIL basic_busy: busy for %0d cycles, required 16", busyc);
    end
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL basic_done_pulse: done=%b one cycle later, required 0", done);
    end
  endtask

  task automatic test_boundaries();
    int cyc, busyc;
    start_op(16'hFFFF, 16'd1);      wait_done("max_by_1", cyc, busyc);   tick();
    start_op(16'hFFFF, 16'hFFFF);   wait_done("max_by_max", cyc, busyc); tick();
    start_op(16'd3, 16'd10);        wait_done("small_by_big", cyc, busyc); tick();
  endtask

  task automatic test_div_zero();
    int cyc, busyc;
    start_op(16'd5, 16'd0);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL dbz_busy: busy=%b after accept, required 0", busy);
    end
    wait_done("dbz", cyc, busyc);
    total++;
    if (cyc != 0 || busyc != 0) begin
      bad++;
      $display("FAIL dbz_latency: done after %0d cycles busy %0d, required 0 and 0", cyc, busyc);
    end
    tick();
    start_op(16'd40, 16'd8);
    wait_done("dbz_clear", cyc, busyc);
    tick();
  endtask

  task automatic test_ignore_start();
    int cyc, busyc;
    start_op(16'd1000, 16'd9);
    repeat (4) tick();
    dividend = 16'd50;
    divisor  = 16'd5;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    wait_done("ignore_start", cyc, busyc);
    tick();
    total++;
    if (busy !== 1'b0 || sbq.size() != 0) begin
      bad++;
      $display("FAIL ignore_start_queued: busy=%b pending=%0d, required 0 and 0", busy, sbq.size());
    end
  endtask

  task automatic test_back_to_back();
    int t, t_first, t_second, cyc, busyc;
    t_first = -1;
    t_second = -1;
    dividend = 16'd1000;
    divisor  = 16'd9;
    start    = 1'b1;
    sbq.push_back(model(16'd1000, 16'd9));
    sbq.push_back(model(16'd1000, 16'd9));
    for (t = 0; t < 60 && t_second < 0; t++) begin
      tick();
      if (done) begin
        if (t_first < 0) begin
          t_first = t;
          wait_done("b2b_first", cyc, busyc);
        end else begin
          t_second = t;
          start = 1'b0;
          wait_done("b2b_second", cyc, busyc);
        end
      end
    end
    start = 1'b0;
    total++;
    if (t_second - t_first != 18) begin
      bad++;
      $display("FAIL b2b_spacing: done spacing %0d, required 18", t_second - t_first);
    end
    tick();
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_extra_op: busy=%b after start dropped, required 0", busy);
    end
  endtask

  task automatic test_async_reset();
    int cyc, busyc;
    start_op(16'd1000, 16'd9);
    void'(sbq.pop_back());
    repeat (7) tick();
    @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    #1;
    total++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 35'd0) begin
      bad++;
      $display("FAIL async_reset: busy=%b done=%b dbz=%b q=%0d r=%0d required all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(negedge Clk);
    prev_done = 1'b0;
    Reset_n = 1'b1;
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_idle: busy=%b done=%b required 0 0", busy, done);
    end
    start_op(16'd20, 16'd6);
    wait_done("after_reset", cyc, busyc);
    tick();
  endtask

  task automatic test_random();
    int cyc, busyc;
    logic [15:0] a, b;
    for (int i = 0; i < 2000; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 16'($urandom_range(1, 15));
        1: b = 16'($urandom_range(0, 2) == 0 ? 0 : 1);
        default: b = $urandom;
      endcase
      start_op(a, b);
      wait_done("random", cyc, busyc);
      tick();
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    test_random();
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: %0d expected results never produced, required 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
